// File: rtl/shift_rotate_seq_pkg.sv
// Shared encodings for the shift/rotate sequencer: ALU op codes, FSM states, operand widths.
// Optional build macro used by the sequencer: SHIFT_SEQ_SATURATE_EN.
package shift_rotate_seq_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_RCL = 3'b010;
    localparam logic [2:0] OP_RCR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SAL = 3'b110;
    localparam logic [2:0] OP_SAR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Left-moving ops share CF = old MSB and the MSB^CF overflow rule.
    function automatic logic is_left_op(input logic [2:0] op);
        return (op == OP_ROL) || (op == OP_RCL) || (op == OP_SHL) || (op == OP_SAL);
    endfunction

endpackage

// File: rtl/shift_rotate_seq_if.sv
// Request/response bundle between execution-unit control and the shift/rotate sequencer.
interface shift_rotate_seq_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic [2:0]       op;
    logic             w;
    logic [15:0]      opA;
    logic [CNT_W-1:0] cnt;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [15:0]      R;
    logic             CF;
    logic             OF;
    logic             flag_upd;

    modport master (
        output start, op, w, opA, cnt, Cin,
        input  busy, done, R, CF, OF, flag_upd
    );

    modport slave (
        input  start, op, w, opA, cnt, Cin,
        output busy, done, R, CF, OF, flag_upd
    );
endinterface

// File: rtl/shift_rotate_seq_step1.sv
// Single-bit shift/rotate step (combinational); byte mode leaves data[15:8] untouched.
import shift_rotate_seq_pkg::*;

module shift_step1 (
    input  logic [15:0] data,
    input  logic        cf,
    input  logic [2:0]  op,
    input  logic        w,
    output logic [15:0] data_next,
    output logic        cf_next,
    output logic        of
);
    logic        msb;
    logic        lsb;
    logic        in_left;
    logic        in_right;
    logic [15:0] shl_v;
    logic [15:0] shr_v;
    logic        res_msb;
    logic        res_msb1;

    always_comb begin
        msb      = w ? data[15] : data[7];
        lsb      = data[0];

        // Bit entering at the vacated end, chosen by op family.
        in_left  = 1'b0;
        in_right = 1'b0;
        case (op)
            OP_ROL:  in_left  = msb;
            OP_RCL:  in_left  = cf;
            OP_ROR:  in_right = lsb;
            OP_RCR:  in_right = cf;
            OP_SAR:  in_right = msb;
            default: begin
                in_left  = 1'b0;
                in_right = 1'b0;
            end
        endcase

        shl_v = w ? {data[14:0], in_left}  : {data[15:8], data[6:0], in_left};
        shr_v = w ? {in_right, data[15:1]} : {data[15:8], in_right, data[7:1]};

        if (is_left_op(op)) begin
            data_next = shl_v;
            cf_next   = msb;
        end else begin
            data_next = shr_v;
            cf_next   = lsb;
        end

        res_msb  = w ? data_next[15] : data_next[7];
        res_msb1 = w ? data_next[14] : data_next[6];

        case (op)
            OP_ROR, OP_RCR: of = res_msb ^ res_msb1;
            OP_SHR:         of = msb;
            OP_SAR:         of = 1'b0;
            default:        of = res_msb ^ cf_next;
        endcase
    end
endmodule

// File: rtl/shift_rotate_seq.sv
// Multi-cycle 8086 shift/rotate sequencer: one bit step per clock, start/busy/done handshake.
// Build macro SHIFT_SEQ_SATURATE_EN: finish SHL/SAL/SHR/SAR with cnt >= width in one RUN cycle.
import shift_rotate_seq_pkg::*;

module shift_rotate_seq #(
    parameter int CNT_W = 5
) (
    input logic              clk,
    input logic              rst,
    shift_rotate_seq_if.slave bus
);
    state_t           state_reg, state_next;
    logic [15:0]      data_reg,  data_next;
    logic             cf_reg,    cf_next;
    logic             of_reg,    of_next;
    logic             fu_reg,    fu_next;
    logic [2:0]       op_reg,    op_next;
    logic             w_reg,     w_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;

    logic [15:0]      step_data;
    logic             step_cf;
    logic             step_of;

    shift_step1 u_step (
        .data      (data_reg),
        .cf        (cf_reg),
        .op        (op_reg),
        .w         (w_reg),
        .data_next (step_data),
        .cf_next   (step_cf),
        .of        (step_of)
    );

`ifdef SHIFT_SEQ_SATURATE_EN
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] BYTE_CNT = CNT_W'(BYTE_W);

    logic        sat_reg, sat_next;
    logic        sat_msb;
    logic        sat_exact;
    logic [15:0] sat_data;
    logic        sat_cf;
    logic        sat_of;

    // Closed-form result once every operand bit has been shifted out.
    always_comb begin
        sat_msb   = w_reg ? data_reg[15] : data_reg[7];
        sat_exact = (cnt_reg == (w_reg ? WORD_CNT : BYTE_CNT));
        sat_data  = w_reg ? 16'h0000 : {data_reg[15:8], 8'h00};
        sat_cf    = 1'b0;
        sat_of    = 1'b0;
        case (op_reg)
            OP_SHL, OP_SAL: begin
                sat_cf = sat_exact & data_reg[0];
                sat_of = sat_cf;
            end
            OP_SHR: sat_cf = sat_exact & sat_msb;
            OP_SAR: begin
                sat_data = w_reg ? {16{sat_msb}} : {data_reg[15:8], {8{sat_msb}}};
                sat_cf   = sat_msb;
            end
            default: sat_cf = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        cf_next    = cf_reg;
        of_next    = of_reg;
        fu_next    = fu_reg;
        op_next    = op_reg;
        w_next     = w_reg;
        cnt_next   = cnt_reg;
`ifdef SHIFT_SEQ_SATURATE_EN
        sat_next   = sat_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    op_next    = bus.op;
                    w_next     = bus.w;
                    data_next  = bus.opA;
                    cf_next    = bus.Cin;
                    of_next    = 1'b0;
                    fu_next    = (bus.cnt != '0);
                    cnt_next   = bus.cnt;
                    state_next = (bus.cnt == '0) ? FIN : RUN;
`ifdef SHIFT_SEQ_SATURATE_EN
                    sat_next   = bus.op[2] && (bus.cnt >= (bus.w ? WORD_CNT : BYTE_CNT));
`endif
                end
            end
            RUN: begin
`ifdef SHIFT_SEQ_SATURATE_EN
                if (sat_reg) begin
                    data_next  = sat_data;
                    cf_next    = sat_cf;
                    of_next    = sat_of;
                    state_next = FIN;
                end else begin
`else
                begin
`endif
                    data_next = step_data;
                    cf_next   = step_cf;
                    of_next   = step_of;
                    cnt_next  = cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1))
                        state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            cf_reg    <= 1'b0;
            of_reg    <= 1'b0;
            fu_reg    <= 1'b0;
            op_reg    <= '0;
            w_reg     <= 1'b0;
            cnt_reg   <= '0;
`ifdef SHIFT_SEQ_SATURATE_EN
            sat_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            cf_reg    <= cf_next;
            of_reg    <= of_next;
            fu_reg    <= fu_next;
            op_reg    <= op_next;
            w_reg     <= w_next;
            cnt_reg   <= cnt_next;
`ifdef SHIFT_SEQ_SATURATE_EN
            sat_reg   <= sat_next;
`endif
        end
    end

    assign bus.busy     = (state_reg == RUN);
    assign bus.done     = (state_reg == FIN);
    assign bus.R        = data_reg;
    assign bus.CF       = cf_reg;
    assign bus.OF       = of_reg;
    assign bus.flag_upd = fu_reg;
endmodule

// File: tb/tb_shift_rotate_seq.sv
// Bench for shift_rotate_seq: arithmetic reference model, per-cycle busy/done/result compare.
module tb_shift_rotate_seq;

    typedef struct packed {
        logic [15:0] r;
        logic        cf;
        logic        of;
        logic        fu;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_rotate_seq_if #(.CNT_W(5)) bus ();
    shift_rotate_seq #(.CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   chk_en = 0;
    bit   act_tx = 0;
    bit   done_seen = 0;
    int   t_start = 0;
    int   t_done = 0;
    res_t exp_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Whole-count arithmetic: rotates by count modulo width, shifts on a wide word.
    function automatic res_t model(input logic [2:0] op, input logic w, input logic [15:0] a,
                                   input int n, input logic cin);
        int W;
        int k;
        logic [63:0] mask, vmask, x, v, rr, t;
        logic signed [63:0] sx;
        logic c, o;
        res_t res;
        W = w ? 16 : 8;
        mask = (64'd1 << W) - 64'd1;
        vmask = (64'd1 << (W + 1)) - 64'd1;
        x = {48'd0, a} & mask;
        rr = x; c = cin; o = 1'b0;
        if (n != 0) begin
            case (op)
                3'd0: begin
                    k = n % W;
                    rr = ((x << k) | (x >> (W - k))) & mask;
                    c = rr[0]; o = rr[W-1] ^ c;
                end
                3'd1: begin
                    k = n % W;
                    rr = ((x >> k) | (x << (W - k))) & mask;
                    c = rr[W-1]; o = rr[W-1] ^ rr[W-2];
                end
                3'd2, 3'd3: begin
                    k = n % (W + 1);
                    v = x | ({63'd0, cin} << W);
                    if (op == 3'd2) v = ((v << k) | (v >> (W + 1 - k))) & vmask;
                    else            v = ((v >> k) | (v << (W + 1 - k))) & vmask;
                    c = v[W]; rr = v & mask;
                    o = (op == 3'd2) ? (rr[W-1] ^ c) : (rr[W-1] ^ rr[W-2]);
                end
                3'd4, 3'd6: begin
                    t = x << n;
                    c = t[W]; rr = t & mask; o = rr[W-1] ^ c;
                end
                3'd5: begin
                    t = x >> (n - 1);
                    c = t[0]; o = t[W-1]; rr = x >> n;
                end
                default: begin
                    sx = x[W-1] ? $signed(x | ~mask) : $signed(x);
                    t = sx >>> (n - 1);
                    c = t[0]; rr = (sx >>> n) & mask; o = 1'b0;
                end
            endcase
        end
        res.r  = w ? rr[15:0] : {a[15:8], rr[7:0]};
        res.cf = c;
        res.of = (n == 0) ? 1'b0 : o;
        res.fu = (n != 0);
        return res;
    endfunction

    function automatic int latency(input logic [2:0] op, input logic w, input int n);
`ifdef SHIFT_SEQ_SATURATE_EN
        if (op[2] && n >= (w ? 16 : 8)) return 2;
`endif
        return n + 1;
    endfunction

    // Per-cycle compare of the handshake and, on the done cycle, the result.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (chk_en) begin
            logic exp_busy, exp_done;
            exp_busy = act_tx && (cyc > t_start) && (cyc < t_done);
            exp_done = act_tx && (cyc == t_done);
            chk("busy", bus.busy, exp_busy);
            chk("done", bus.done, exp_done);
            if (exp_done) begin
                chk("R", bus.R, exp_res.r);
                chk("CF", bus.CF, exp_res.cf);
                chk("OF", bus.OF, exp_res.of);
                chk("flag_upd", bus.flag_upd, exp_res.fu);
                act_tx = 0;
                done_seen = 1;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic w, input logic [15:0] a,
                         input int n, input logic cin);
        @(negedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.w = w; bus.opA = a; bus.cnt = 5'(n); bus.Cin = cin;
        t_start = cyc;
        t_done = cyc + latency(op, w, n);
        exp_res = model(op, w, a, n, cin);
        done_seen = 0;
        act_tx = 1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        bus.op = ~op; bus.opA = ~a; bus.cnt = ~bus.cnt; bus.Cin = ~cin; bus.w = ~w;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 64 && !done_seen; i++) begin
            @(negedge clk); #2;
        end
        if (!done_seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            act_tx = 0;
        end
    endtask

    task automatic run(input logic [2:0] op, input logic w, input logic [15:0] a,
                       input int n, input logic cin);
        issue(op, w, a, n, cin);
        wait_done();
        $display("tx op=%0d w=%0d opA=%04h cnt=%0d Cin=%0d -> R=%04h CF=%0d OF=%0d fu=%0d",
                 op, w, a, n, cin, bus.R, bus.CF, bus.OF, bus.flag_upd);
    endtask

    logic [15:0] pats [4] = '{16'h8001, 16'h5A3C, 16'hF0F1, 16'h0081};
    int cnts [7] = '{1, 3, 8, 9, 16, 17, 31};

    initial begin
        bus.start = 0; bus.op = 0; bus.w = 0; bus.opA = 0; bus.cnt = 0; bus.Cin = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_R", bus.R, 16'h0000);
        chk("rst_flags", {bus.CF, bus.OF, bus.flag_upd}, 3'b000);
        rst = 0;
        chk_en = 1;

        // Hand-computed vectors.
        run(3'd0, 1'b1, 16'h8001, 1, 1'b0);
        chk("rol_lit", {bus.R, bus.CF, bus.OF, bus.flag_upd}, {16'h0003, 3'b111});
        chk("rol_lat", t_done - t_start, 2);
        run(3'd3, 1'b0, 16'hAA01, 1, 1'b0);
        chk("rcr_lit", {bus.R, bus.CF, bus.OF}, {16'hAA00, 2'b10});
        run(3'd7, 1'b1, 16'h8000, 4, 1'b0);
        chk("sar_lit", {bus.R, bus.CF, bus.OF}, {16'hF800, 2'b00});
        run(3'd4, 1'b0, 16'h0081, 2, 1'b1);
        chk("shl_lit", {bus.R, bus.CF, bus.OF}, {16'h0004, 2'b00});
        run(3'd2, 1'b1, 16'h1234, 0, 1'b1);
        chk("cnt0_lit", {bus.R, bus.CF, bus.OF, bus.flag_upd}, {16'h1234, 3'b100});
        chk("cnt0_lat", t_done - t_start, 1);

        // Every op and width across boundary counts.
        for (int op = 0; op < 8; op++)
            for (int w = 0; w < 2; w++)
                for (int ci = 0; ci < 7; ci++)
                    run(3'(op), w[0], pats[(op + ci + w) % 4], cnts[ci], op[0] ^ ci[0]);

        // Start while busy and start during done are both ignored.
        issue(3'd1, 1'b1, 16'h1357, 20, 1'b0);
        repeat (2) @(negedge clk);
        #1 bus.start = 1'b1; bus.op = 3'd4; bus.cnt = 5'd2;
        @(negedge clk); #1 bus.start = 1'b0;
        wait_done();
        $display("tx op=1 w=1 opA=1357 cnt=20 (with ignored restart) -> R=%04h CF=%0d OF=%0d",
                 bus.R, bus.CF, bus.OF);
        bus.start = 1'b1; bus.cnt = 5'd3;
        @(negedge clk); #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        issue(3'd1, 1'b1, 16'hBEEF, 20, 1'b1);
        while (cyc < t_start + 5) @(negedge clk);
        #1 rst = 1'b1;
        act_tx = 0;
        @(negedge clk); #1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_R", bus.R, 16'h0000);
        chk("abort_flags", {bus.CF, bus.OF, bus.flag_upd}, 3'b000);
        $display("tx op=1 w=1 opA=BEEF cnt=20 aborted by rst");
        rst = 1'b0;
        repeat (25) @(negedge clk);
        run(3'd5, 1'b1, 16'h8000, 16, 1'b0);

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
